// File: rtl/uart_boot_pkg.sv
// Shared encodings for the UART boot loader: FSM states, error codes, frame magic.
// UART_BOOT_CHECKSUM_EN adds the trailing checksum state.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
`ifdef UART_BOOT_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERROR
  } boot_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FRAME = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;

endpackage

// File: rtl/uart_boot_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, start-glitch rejection.
module uart_boot_rx
  import uart_boot_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned   CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;
  logic          rx_s, fall;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;

  always_ff @(posedge clock) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      // Line back high at half a bit: a glitch, not a start bit.
      RX_START: if (cnt_q == HALF_LAST) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_q == BIT_LAST && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt_q == BIT_LAST) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    sync_d  = {sync_q[0], rx};
    prev_d  = rx_s;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE:  cnt_d = '0;
      RX_START: if (cnt_q == HALF_LAST) begin
        cnt_d = '0;
        bit_d = '0;
      end
      RX_DATA:  if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
      end
      RX_STOP:  if (cnt_q == BIT_LAST) begin
        cnt_d  = '0;
        vld_d  = rx_s;
        ferr_d = ~rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    byte_valid = vld_q;
    byte_data  = shift_q;
    frame_err  = ferr_q;
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5/LEN/payload[/CSUM] frames into memory writes, holds the CPU until done.
// Define UART_BOOT_CHECKSUM_EN to expect and verify a trailing 8-bit payload sum.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 868,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_uart_rx,
  output logic        io_mem_valid,
  input  logic        io_mem_ready,
  output logic [31:0] io_mem_addr,
  output logic [31:0] io_mem_wdata,
  output logic [3:0]  io_mem_wstrb,
  output logic        io_cpu_hold,
  output logic        io_done,
  output logic [1:0]  io_error,
  output logic [15:0] io_words
);

`ifdef UART_BOOT_CHECKSUM_EN
  localparam boot_state_e ST_AFTER_LAST = ST_CSUM;
`else
  localparam boot_state_e ST_AFTER_LAST = ST_DONE;
`endif

  logic        rx_vld, rx_ferr;
  logic [7:0]  rx_data;

  boot_state_e state_q, state_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [15:0] words_q, words_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  hold_data_q, hold_data_d;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic        in_vld, in_frame, len_bad, hs, last_word, restart;
  logic [7:0]  in_data;
  logic [15:0] len_new;
  mem_req_t    req;

  uart_boot_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (io_uart_rx),
    .byte_valid (rx_vld),
    .byte_data  (rx_data),
    .frame_err  (rx_ferr)
  );

  // A byte that lands during a pending write is parked and consumed once back in DATA/CSUM.
  always_comb begin
    in_vld    = hold_vld_q | rx_vld;
    in_data   = hold_vld_q ? hold_data_q : rx_data;
    len_new   = {in_data, len_q[7:0]};
    len_bad   = (len_new == 16'd0) || (32'(len_new) > MAX_WORDS);
    hs        = (state_q == ST_WRITE) && io_mem_ready;
    last_word = (words_q + 16'd1) == len_q;
    in_frame  = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (in_frame && rx_ferr) begin
      state_d = ST_ERROR;
      err_d   = ERR_FRAME;
    end else begin
      case (state_q)
        ST_IDLE:  if (in_vld && in_data == BOOT_MAGIC) state_d = ST_LEN0;
        ST_LEN0:  if (in_vld) state_d = ST_LEN1;
        ST_LEN1:  if (in_vld) begin
          if (len_bad) begin
            state_d = ST_ERROR;
            err_d   = ERR_LEN;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA:  if (in_vld && bcnt_q == 2'd3) state_d = ST_WRITE;
        ST_WRITE: begin
          if (rx_vld && hold_vld_q) begin
            state_d = ST_ERROR;
            err_d   = ERR_CSUM;
          end else if (hs) begin
            state_d = last_word ? ST_AFTER_LAST : ST_DATA;
          end
        end
`ifdef UART_BOOT_CHECKSUM_EN
        ST_CSUM:  if (in_vld) begin
          if (in_data == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
            err_d   = ERR_CSUM;
          end
        end
`endif
        ST_ERROR: if (in_vld && in_data == BOOT_MAGIC) begin
          state_d = ST_LEN0;
          err_d   = ERR_NONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    len_d       = len_q;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    words_d     = words_q;
    hold_vld_d  = 1'b0;
    hold_data_d = hold_data_q;
`ifdef UART_BOOT_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    restart     = (state_d == ST_LEN0) && (state_q != ST_LEN0);
    if (state_q == ST_WRITE) begin
      hold_vld_d = hold_vld_q | rx_vld;
      if (rx_vld) hold_data_d = rx_data;
    end
    if (in_vld && state_q == ST_LEN0) len_d[7:0]  = in_data;
    if (in_vld && state_q == ST_LEN1) len_d[15:8] = in_data;
    if (in_vld && state_q == ST_DATA) begin
      word_d = {in_data, word_q[31:8]};
      bcnt_d = bcnt_q + 2'd1;
`ifdef UART_BOOT_CHECKSUM_EN
      sum_d  = sum_q + in_data;
`endif
    end
    if (hs) words_d = words_q + 16'd1;
    if (restart) begin
      words_d = '0;
      bcnt_d  = '0;
`ifdef UART_BOOT_CHECKSUM_EN
      sum_d   = '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q       <= ERR_NONE;
      len_q       <= '0;
      word_q      <= '0;
      bcnt_q      <= '0;
      words_q     <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      err_q       <= err_d;
      len_q       <= len_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      words_q     <= words_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
`ifdef UART_BOOT_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  always_comb begin
    req.valid    = (state_q == ST_WRITE);
    req.addr     = BASE_ADDR + {14'd0, words_q, 2'b00};
    req.wdata    = word_q;
    req.wstrb    = req.valid ? 4'hF : 4'h0;
    io_mem_valid = req.valid;
    io_mem_addr  = req.addr;
    io_mem_wdata = req.wdata;
    io_mem_wstrb = req.wstrb;
    io_done      = (state_q == ST_DONE);
    io_cpu_hold  = (state_q != ST_DONE);
    io_error     = err_q;
    io_words     = words_q;
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: table vectors, hand sequences for corner cases, random frames vs a frame-level model.
module tb_uart_boot_loader;
  import uart_boot_pkg::*;

  localparam int unsigned CLK_DIV = 8;
  localparam logic [31:0] BASE    = 32'h1000_0100;
  localparam int unsigned MAXW    = 4;
`ifdef UART_BOOT_CHECKSUM_EN
  localparam int NB_GOOD = 12;
`else
  localparam int NB_GOOD = 11;
`endif
  localparam logic [95:0] GOOD = 96'hA5_02_00_11_22_33_44_55_66_77_88_64;
  localparam logic [31:0] GW0  = 32'h4433_2211;
  localparam logic [31:0] GW1  = 32'h8877_6655;

  logic        clock, reset, rx, ready;
  logic        io_mem_valid, io_cpu_hold, io_done;
  logic [31:0] io_mem_addr, io_mem_wdata;
  logic [3:0]  io_mem_wstrb;
  logic [1:0]  io_error;
  logic [15:0] io_words;

  uart_boot_loader #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .io_uart_rx(rx),
    .io_mem_valid(io_mem_valid), .io_mem_ready(ready),
    .io_mem_addr(io_mem_addr), .io_mem_wdata(io_mem_wdata), .io_mem_wstrb(io_mem_wstrb),
    .io_cpu_hold(io_cpu_hold), .io_done(io_done), .io_error(io_error), .io_words(io_words)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory side: ready policy, write capture, hold-stable checking.
  int          rdy_mode = 0;
  int          rdy_dly  = 0;
  int          vcnt     = 0;
  logic        prev_v = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_a, prev_d;
  logic [31:0] wr_a[$], wr_d[$], exp_q[$];
  logic [7:0]  tx_q[$];

  always @(negedge clock) begin
    if (!io_mem_valid) vcnt = 0;
    case (rdy_mode)
      0:       ready = 1'b1;
      1:       ready = io_mem_valid && (vcnt >= rdy_dly);
      default: ready = 1'b0;
    endcase
    if (io_mem_valid) begin
      vcnt++;
      chk("wstrb", 32'(io_mem_wstrb), 32'hF);
      if (prev_v && !prev_hs) begin
        chk("stable_addr", io_mem_addr, prev_a);
        chk("stable_data", io_mem_wdata, prev_d);
      end
      if (ready) begin
        wr_a.push_back(io_mem_addr);
        wr_d.push_back(io_mem_wdata);
      end
    end
    prev_v  = io_mem_valid;
    prev_hs = io_mem_valid && ready;
    prev_a  = io_mem_addr;
    prev_d  = io_mem_wdata;
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clock);
    end
    rx = stop;
    repeat (CLK_DIV) @(negedge clock);
    rx = 1'b1;
    repeat (CLK_DIV) @(negedge clock);
  endtask

  task automatic send_q();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
  endtask

  task automatic load_frame(input logic [95:0] fr, input int nb);
    tx_q.delete();
    for (int i = 0; i < nb; i++) tx_q.push_back(fr[95-8*i -: 8]);
  endtask

  task automatic check_status(input string tag, input logic [1:0] err, input logic done,
                              input logic [15:0] words);
    chk({tag, "_err"},   32'(io_error),    32'(err));
    chk({tag, "_done"},  32'(io_done),     32'(done));
    chk({tag, "_hold"},  32'(io_cpu_hold), 32'(!done));
    chk({tag, "_words"}, 32'(io_words),    32'(words));
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_d.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_d.size(); i++) begin
      chk({tag, "_addr"}, wr_a[i], BASE + 32'(4 * i));
      chk({tag, "_data"}, wr_d[i], exp_q[i]);
    end
  endtask

  typedef struct {
    logic [95:0] frame;
    int          nb;
    int          mode;
    int          dly;
    logic [1:0]  err;
    logic        done;
    logic [15:0] words;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;
  vec_t vt[$];

  initial begin
    reset = 1'b1;
    rx    = 1'b1;

    vt.push_back(vec_t'{GOOD, NB_GOOD, 0, 0,  ERR_NONE, 1'b1, 16'd2, 2, GW0, GW1});
    vt.push_back(vec_t'{GOOD, NB_GOOD, 1, 20, ERR_NONE, 1'b1, 16'd2, 2, GW0, GW1});
    vt.push_back(vec_t'{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 3, 0, 0, ERR_LEN, 1'b0, 16'd0, 0, 32'h0, 32'h0});
    vt.push_back(vec_t'{96'hA5_05_00_00_00_00_00_00_00_00_00_00, 3, 0, 0, ERR_LEN, 1'b0, 16'd0, 0, 32'h0, 32'h0});
    vt.push_back(vec_t'{96'h00_FF_A5_01_00_DE_AD_BE_EF_38_00_00, NB_GOOD - 2, 1, 5, ERR_NONE, 1'b1, 16'd1, 1,
                        32'hEFBE_ADDE, 32'h0});
`ifdef UART_BOOT_CHECKSUM_EN
    vt.push_back(vec_t'{96'hA5_02_00_11_22_33_44_55_66_77_88_65, 12, 0, 0, ERR_CSUM, 1'b0, 16'd2, 2, GW0, GW1});
`endif

    // Reset state
    do_reset();
    chk("rst_valid", 32'(io_mem_valid), 32'h0);
    chk("rst_addr",  io_mem_addr, BASE);
    chk("rst_wdata", io_mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(io_mem_wstrb), 32'h0);
    check_status("rst", ERR_NONE, 1'b0, 16'd0);

    for (int v = 0; v < vt.size(); v++) begin
      do_reset();
      rdy_mode = vt[v].mode;
      rdy_dly  = vt[v].dly;
      load_frame(vt[v].frame, vt[v].nb);
      send_q();
      repeat (60) @(negedge clock);
      exp_q.delete();
      if (vt[v].nwr > 0) exp_q.push_back(vt[v].w0);
      if (vt[v].nwr > 1) exp_q.push_back(vt[v].w1);
      check_writes($sformatf("vec%0d", v));
      check_status($sformatf("vec%0d", v), vt[v].err, vt[v].done, vt[v].words);
    end

    // Error then retry with a good frame
    do_reset();
    rdy_mode = 0;
`ifdef UART_BOOT_CHECKSUM_EN
    load_frame(96'hA5_02_00_11_22_33_44_55_66_77_88_65, 12);
    send_q();
    repeat (20) @(negedge clock);
    check_status("bad", ERR_CSUM, 1'b0, 16'd2);
`else
    load_frame(96'hA5_05_00_00_00_00_00_00_00_00_00_00, 3);
    send_q();
    repeat (20) @(negedge clock);
    check_status("bad", ERR_LEN, 1'b0, 16'd0);
`endif
    wr_a.delete();
    wr_d.delete();
    load_frame(GOOD, NB_GOOD);
    send_q();
    repeat (40) @(negedge clock);
    exp_q = {GW0, GW1};
    check_writes("retry");
    check_status("retry", ERR_NONE, 1'b1, 16'd2);

    // Start-bit glitches: idle line, then mid-frame
    do_reset();
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clock);
    check_status("glitch_idle", ERR_NONE, 1'b0, 16'd0);
    load_frame(GOOD, NB_GOOD);
    send_byte(tx_q[0], 1'b1);
    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clock);
    check_status("glitch_mid", ERR_NONE, 1'b0, 16'd0);
    for (int i = 1; i < NB_GOOD; i++) send_byte(tx_q[i], 1'b1);
    repeat (40) @(negedge clock);
    exp_q = {GW0, GW1};
    check_writes("glitch");
    check_status("glitch_end", ERR_NONE, 1'b1, 16'd2);

    // Framing error on a payload byte
    do_reset();
    load_frame(GOOD, 4);
    send_q();
    send_byte(8'h22, 1'b0);
    repeat (5) @(negedge clock);
    check_status("frame", ERR_FRAME, 1'b0, 16'd0);

    // Memory stalls past one byte time: the held byte is fine, the next one overruns
    do_reset();
    rdy_mode = 2;
    load_frame(GOOD, 8);
    send_q();
    repeat (5) @(negedge clock);
    chk("ovr_pre_valid", 32'(io_mem_valid), 32'h1);
    check_status("ovr_pre", ERR_NONE, 1'b0, 16'd0);
    send_byte(8'h66, 1'b1);
    repeat (5) @(negedge clock);
    check_status("ovr", ERR_CSUM, 1'b0, 16'd0);

    // Reset with a write pending
    do_reset();
    rdy_mode = 2;
    load_frame(96'hA5_01_00_DE_AD_BE_EF_00_00_00_00_00, 7);
    send_q();
    repeat (10) @(negedge clock);
    chk("rmw_valid", 32'(io_mem_valid), 32'h1);
    chk("rmw_addr",  io_mem_addr, BASE);
    chk("rmw_data",  io_mem_wdata, 32'hEFBE_ADDE);
    reset = 1'b1;
    @(negedge clock);
    chk("rmw_valid_after", 32'(io_mem_valid), 32'h0);
    chk("rmw_addr_after",  io_mem_addr, BASE);
    check_status("rmw", ERR_NONE, 1'b0, 16'd0);
    chk("rmw_nwr", 32'(wr_d.size()), 32'h0);
    reset = 1'b0;
    rdy_mode = 0;
    load_frame(GOOD, NB_GOOD);
    send_q();
    repeat (40) @(negedge clock);
    check_status("rmw_reload", ERR_NONE, 1'b1, 16'd2);

    // Random frames against a frame-level model
    for (int r = 0; r < 8; r++) begin
      int          len;
      logic [7:0]  sum;
      logic [31:0] word;
      logic [1:0]  e_err;
      logic        e_done;
      logic [15:0] e_words;
      do_reset();
      rdy_mode = int'($urandom_range(0, 1));
      rdy_dly  = int'($urandom_range(0, 30));
      len      = int'($urandom_range(0, MAXW + 1));
      sum      = 8'h00;
      tx_q     = {8'hA5, 8'(len), 8'h00};
      exp_q.delete();
      if (len >= 1 && len <= int'(MAXW)) begin
        for (int w = 0; w < len; w++) begin
          word = $urandom;
          exp_q.push_back(word);
          for (int b = 0; b < 4; b++) begin
            tx_q.push_back(word[8*b +: 8]);
            sum = sum + word[8*b +: 8];
          end
        end
        e_err   = ERR_NONE;
        e_done  = 1'b1;
        e_words = 16'(len);
      end else begin
        e_err   = ERR_LEN;
        e_done  = 1'b0;
        e_words = 16'd0;
      end
`ifdef UART_BOOT_CHECKSUM_EN
      if (e_err == ERR_NONE) begin
        if ($urandom_range(0, 3) == 0) begin
          tx_q.push_back(sum + 8'd1 + 8'($urandom_range(0, 254)));
          e_err  = ERR_CSUM;
          e_done = 1'b0;
        end else begin
          tx_q.push_back(sum);
        end
      end
`endif
      send_q();
      repeat (60) @(negedge clock);
      check_writes($sformatf("rnd%0d", r));
      check_status($sformatf("rnd%0d", r), e_err, e_done, e_words);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
